cpld_disp_arbiter: RTL and testbench
====================================

Name: cpld_disp_arbiter

Overview:
- Shares the CPLD board's LED bank and two 7-segment digits between two independent requesters, e.g. the CIC data path and a status/debug source.
- Arbitration is round-robin with minimum and maximum hold times, so the display never flickers and neither requester can starve the other.
- Encodes each owner's 8-bit value as two hex digits in segment format.
- Its outputs feed the LEDs_in, disp1_in and disp2_in inputs of the CPLD serial peripheral.
- A debug override, driven from board switches, pins the display to one requester.

Parameters:
- MIN_HOLD, 50000, cycles an owner keeps the grant before it can be released or preempted (1 ms at 50 MHz); must be at least 1.
- MAX_HOLD, 50000000, cycles after which an owner is forcibly released if the other requester is waiting (1 s); must be greater than MIN_HOLD.
- CW, 26, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk50  in  1  system clock, 50 MHz
- rstn_in  in  1  asynchronous active-low reset
- req  in  2  request, one bit per requester
- val0  in  8  requester 0 display value (hex byte)
- led0  in  8  requester 0 LED pattern
- val1  in  8  requester 1 display value
- led1  in  8  requester 1 LED pattern
- force_en  in  1  override enable (debug switch)
- force_sel  in  1  requester pinned when force_en=1
- gnt  out  2  grant, one-hot or zero
- busy  out  1  state is GRANT or HOLD
- LEDs_out  out  8  LED pattern to the CPLD peripheral
- disp1_out  out  8  segments for the high nibble
- disp2_out  out  8  segments for the low nibble

Behaviour:
- Clocking and reset:
  - Single clock domain, clk50.
  - rstn_in low asynchronously sets gnt=0, busy=0, LEDs_out=0, disp1_out=0, disp2_out=0, state=IDLE, hold counter=0, rr_ptr=0.
  - Reset mid-grant drops gnt immediately and blanks the outputs.
- Segment encoding:
  - Bit order {dp,g,f,e,d,c,b,a}, active-high, dp always 0.
  - Standard hex table: 0=8'h3F, 1=8'h06, 2=8'h5B, 3=8'h4F, 4=8'h66, 5=8'h6D, 6=8'h7D, 7=8'h07, 8=8'h7F, 9=8'h6F, A=8'h77, b=8'h7C, C=8'h39, d=8'h5E, E=8'h79, F=8'h71.
  - disp1_out encodes val[7:4]; disp2_out encodes val[3:0].
- Output data path:
  - While gnt[i]=1, LEDs_out, disp1_out and disp2_out are registered from val_i/led_i every cycle (1-cycle latency).
  - When gnt=0, the outputs hold their last values.
- State machine (IDLE, GRANT, HOLD):
  - IDLE:
    - If force_en=1 and req[force_sel]=1, grant force_sel.
    - Otherwise, if any req bit is set, grant by round robin: rr_ptr names the preferred requester; if only one requests, grant it.
    - gnt rises on the clock edge after req is sampled; move to GRANT; counter=0.
  - GRANT:
    - Counter increments each cycle.
    - Owner req drops before MIN_HOLD: gnt stays high and outputs keep tracking the value inputs until the counter reaches MIN_HOLD.
    - When the counter reaches MIN_HOLD, go to HOLD.
  - HOLD:
    - Counter keeps incrementing and saturates at MAX_HOLD.
    - Release when the owner's req=0, or when the counter is at least MAX_HOLD and the other req=1.
    - On release: gnt=0, rr_ptr set to the non-owner, return to IDLE; re-grant is possible on the next cycle (1 idle cycle minimum).
    - If the owner keeps req high and the other requester is idle, there is no MAX_HOLD release.
- Force override:
  - If force_en=1 and force_sel differs from the current owner, release in the next cycle regardless of hold state, then grant force_sel from IDLE.
  - While force_en=1, the non-selected requester is never granted.
  - force_en=1 while req[force_sel]=0: the current owner is released and the state idles; no grant is issued.
- Simultaneous events:
  - Both req rise in the same cycle: the rr_ptr requester wins.
  - Owner drops req in the same cycle MAX_HOLD is reached: a single release.
- Invariants: gnt never has both bits set; busy = |gnt.

Test Plan:
- Reset with MIN_HOLD=4, MAX_HOLD=20: hold rstn_in low -> all outputs 0, gnt=2'b00. Release reset, then raise req=2'b01 with val0=8'h3A, led0=8'h81 -> gnt=2'b01 one cycle later; next cycle disp1_out=8'h4F, disp2_out=8'h77, LEDs_out=8'h81.
- Minimum hold: req0 pulses for 1 cycle -> gnt0 stays high exactly 4 cycles plus the HOLD exit cycle, then drops; outputs freeze at the last val0.
- Simultaneous requests: req=2'b11 from reset (rr_ptr=0) -> req0 granted. req0 kept high -> release at counter=20, gnt=2'b10 two cycles later; req1 held forever -> req1 released at 20 so req0 is granted again.
- Force override: owner=0 in HOLD; set force_en=1, force_sel=1, req=2'b11 -> gnt0 drops next cycle, gnt1 rises after the IDLE cycle; req0 is never granted while force_en=1.
- Asynchronous reset mid-grant: assert rstn_in between clock edges while gnt=2'b10 -> gnt and all outputs are 0 immediately, without waiting for a clock edge.
- Encoding sweep: owner val steps 8'h00..8'hFF -> disp1_out/disp2_out match the table for every nibble, with dp=0.

Source files
------------

// File: rtl/cpld_disp_arbiter.sv
// cpld_disp_arbiter: round-robin owner of the CPLD LED bank and two hex digits,
// with min/max hold times and a switch-driven override.
module cpld_disp_arbiter #(
   parameter int MIN_HOLD = 50000,
   parameter int MAX_HOLD = 50000000,
   parameter int CW       = 26
) (
   input  logic       clk50,
   input  logic       rstn_in,
   input  logic [1:0] req,
   input  logic [7:0] val0,
   input  logic [7:0] led0,
   input  logic [7:0] val1,
   input  logic [7:0] led1,
   input  logic       force_en,
   input  logic       force_sel,
   output logic [1:0] gnt,
   output logic       busy,
   output logic [7:0] LEDs_out,
   output logic [7:0] disp1_out,
   output logic [7:0] disp2_out
);
   typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
   state_t state, state_nx;
   logic owner, owner_nx, rr_ptr, rr_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_inc;
   logic frc_rel, hold_rel, at_max;
   logic [7:0] val_sel;

   function automatic logic [7:0] seg(input logic [3:0] n);
      case (n)
         4'h0: seg = 8'h3F;
         4'h1: seg = 8'h06;
         4'h2: seg = 8'h5B;
         4'h3: seg = 8'h4F;
         4'h4: seg = 8'h66;
         4'h5: seg = 8'h6D;
         4'h6: seg = 8'h7D;
         4'h7: seg = 8'h07;
         4'h8: seg = 8'h7F;
         4'h9: seg = 8'h6F;
         4'hA: seg = 8'h77;
         4'hB: seg = 8'h7C;
         4'hC: seg = 8'h39;
         4'hD: seg = 8'h5E;
         4'hE: seg = 8'h79;
         default: seg = 8'h71;
      endcase
   endfunction

   assign cnt_inc  = cnt + CW'(1);
   assign at_max   = cnt >= CW'(MAX_HOLD);
   // override preempts an owner it does not select, or idles when its pick is not requesting
   assign frc_rel  = force_en && (force_sel != owner || !req[force_sel]);
   assign hold_rel = !req[owner] || (at_max && req[~owner]);

   always_ff @(posedge clk50 or negedge rstn_in)
      if (!rstn_in) begin
         state  <= IDLE;
         owner  <= 1'b0;
         cnt    <= '0;
         rr_ptr <= 1'b0;
      end else begin
         state  <= state_nx;
         owner  <= owner_nx;
         cnt    <= cnt_nx;
         rr_ptr <= rr_nx;
      end

   always_comb begin
      state_nx = state;
      owner_nx = owner;
      cnt_nx   = cnt;
      rr_nx    = rr_ptr;
      case (state)
         IDLE: if (force_en ? req[force_sel] : |req) begin
            state_nx = GRANT;
            cnt_nx   = '0;
            owner_nx = force_en ? force_sel : (req[rr_ptr] ? rr_ptr : ~rr_ptr);
         end
         GRANT: begin
            cnt_nx   = cnt_inc;
            state_nx = (cnt_inc == CW'(MIN_HOLD)) ? HOLD : GRANT;
         end
         HOLD: cnt_nx = at_max ? cnt : cnt_inc;
         default: state_nx = IDLE;
      endcase
      if (state != IDLE && (frc_rel || (state == HOLD && hold_rel))) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         rr_nx    = ~owner;
      end
   end

   always_comb begin
      gnt  = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
      busy = |gnt;
   end

   assign val_sel = owner ? val1 : val0;

   always_ff @(posedge clk50 or negedge rstn_in)
      if (!rstn_in) begin
         LEDs_out  <= 8'h00;
         disp1_out <= 8'h00;
         disp2_out <= 8'h00;
      end else if (state != IDLE) begin
         LEDs_out  <= owner ? led1 : led0;
         disp1_out <= seg(val_sel[7:4]);
         disp2_out <= seg(val_sel[3:0]);
      end
endmodule

// File: tb/tb_cpld_disp_arbiter.sv
// tb_cpld_disp_arbiter: directed checks of grant timing, holds, override,
// async reset and the hex segment table, with MIN_HOLD=4, MAX_HOLD=20.
module tb_cpld_disp_arbiter;
   logic clk50 = 1'b0;
   logic rstn_in;
   logic [1:0] req;
   logic [7:0] val0, led0, val1, led1;
   logic force_en, force_sel;
   logic [1:0] gnt;
   logic busy;
   logic [7:0] LEDs_out, disp1_out, disp2_out;
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   always #5 clk50 = ~clk50;

   cpld_disp_arbiter #(.MIN_HOLD(4), .MAX_HOLD(20), .CW(8)) dut (
      .clk50(clk50), .rstn_in(rstn_in), .req(req),
      .val0(val0), .led0(led0), .val1(val1), .led1(led1),
      .force_en(force_en), .force_sel(force_sel),
      .gnt(gnt), .busy(busy), .LEDs_out(LEDs_out),
      .disp1_out(disp1_out), .disp2_out(disp2_out)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk50);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [7:0] l, input logic [7:0] d1, input logic [7:0] d2);
      chk({tag, "_led"}, LEDs_out, l);
      chk({tag, "_d1"}, disp1_out, d1);
      chk({tag, "_d2"}, disp2_out, d2);
   endtask

   initial begin
      rstn_in = 1'b0; req = 2'b00; force_en = 1'b0; force_sel = 1'b0;
      val0 = 8'h00; led0 = 8'h00; val1 = 8'hA5; led1 = 8'h3C;
      #3;
      chk("rst_gnt", {6'd0, gnt}, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      chk_out("rst", 8'h00, 8'h00, 8'h00);
      step(2);
      rstn_in = 1'b1;
      step(1);
      // first grant and one-cycle-pulse request (minimum hold)
      req = 2'b01; val0 = 8'h3A; led0 = 8'h81;
      step(1);
      chk("g1_gnt", {6'd0, gnt}, 8'h01);
      chk("g1_busy", {7'd0, busy}, 8'h01);
      req = 2'b00;
      step(1);
      chk_out("g1", 8'h81, 8'h4F, 8'h77);
      chk("mh_gnt_b", {6'd0, gnt}, 8'h01);
      val0 = 8'hC5; led0 = 8'h5A;
      step(1);
      chk_out("track", 8'h5A, 8'h39, 8'h6D);
      chk("mh_gnt_c", {6'd0, gnt}, 8'h01);
      step(1);
      chk("mh_gnt_d", {6'd0, gnt}, 8'h01);
      step(1);
      chk("mh_gnt_e", {6'd0, gnt}, 8'h01);
      val0 = 8'h7E; led0 = 8'hE7;
      step(1);
      chk("mh_gnt_f", {6'd0, gnt}, 8'h00);
      chk("mh_busy_f", {7'd0, busy}, 8'h00);
      chk_out("last", 8'hE7, 8'h07, 8'h79);
      val0 = 8'h11; led0 = 8'h22;
      step(1);
      chk("frz_gnt", {6'd0, gnt}, 8'h00);
      chk_out("frz", 8'hE7, 8'h07, 8'h79);
      // simultaneous requests from a fresh reset: rr_ptr=0 wins
      rstn_in = 1'b0;
      step(1);
      chk_out("rst2", 8'h00, 8'h00, 8'h00);
      rstn_in = 1'b1;
      req = 2'b11;
      step(1);
      chk("sim_gnt0", {6'd0, gnt}, 8'h01);
      step(20);
      chk("max_hold0", {6'd0, gnt}, 8'h01);
      step(1);
      chk("max_rel0", {6'd0, gnt}, 8'h00);
      step(1);
      chk("rr_gnt1", {6'd0, gnt}, 8'h02);
      step(20);
      chk("max_hold1", {6'd0, gnt}, 8'h02);
      step(1);
      chk("max_rel1", {6'd0, gnt}, 8'h00);
      step(1);
      chk("rr_gnt0", {6'd0, gnt}, 8'h01);
      // force override while owner 0 is in HOLD
      step(5);
      force_en = 1'b1; force_sel = 1'b1;
      step(1);
      chk("frc_drop", {6'd0, gnt}, 8'h00);
      step(1);
      chk("frc_gnt1", {6'd0, gnt}, 8'h02);
      for (int i = 0; i < 30; i++) begin
         step(1);
         chk("frc_no0", {7'd0, gnt[0]}, 8'h00);
      end
      begin
         int k;
         k = 0;
         while (gnt !== 2'b10 && k < 5) begin
            step(1);
            k++;
         end
         chk("frc_wait", {6'd0, gnt}, 8'h02);
      end
      // override pinned to an idle requester releases and issues nothing
      force_sel = 1'b0; req = 2'b10;
      step(1);
      chk("frc_idle_rel", {6'd0, gnt}, 8'h00);
      step(3);
      chk("frc_idle_none", {6'd0, gnt}, 8'h00);
      force_en = 1'b0;
      step(1);
      chk("unforce_gnt1", {6'd0, gnt}, 8'h02);
      step(1);
      chk_out("own1", 8'h3C, 8'h77, 8'h6D);
      // asynchronous reset between edges
      #2;
      rstn_in = 1'b0;
      #1;
      chk("arst_gnt", {6'd0, gnt}, 8'h00);
      chk("arst_busy", {7'd0, busy}, 8'h00);
      chk_out("arst", 8'h00, 8'h00, 8'h00);
      step(1);
      rstn_in = 1'b1;
      // encoding sweep across all byte values
      req = 2'b01; val0 = 8'h00;
      step(1);
      chk("sw_gnt", {6'd0, gnt}, 8'h01);
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = i[7:0];
         val0 = v; led0 = ~v;
         step(1);
         chk("sw_d1", disp1_out, tbl[v[7:4]]);
         chk("sw_d2", disp2_out, tbl[v[3:0]]);
         chk("sw_led", LEDs_out, ~v);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
